// File: rtl/spmv_row_accumulator_if.sv
// Product-beat input stream and row-result output of the SpMV row accumulator.
interface spmv_row_accumulator_if #(
    parameter int DATA_W = 24,
    parameter int ACC_W  = 32,
    parameter int ROW_W  = 11,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ROW_W-1:0]  in_row;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [ROW_W-1:0]  out_row;
    logic [CNT_W-1:0]  out_nnz;
    logic              out_sat;

    modport master (
        output in_valid, in_data, in_row, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_nnz, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_row, in_last, out_ready,
        output in_ready, out_valid, out_data, out_row, out_nnz, out_sat
    );
endinterface

// File: rtl/spmv_row_accumulator.sv
// Row accumulator: products summed round-robin into LANES partial sums, then a registered pairwise tree.
// Latency: last beat in cycle t -> out_valid in cycle t+1+log2(LANES); SATURATE_EN selects saturating adds.
// Backpressure: in_ready drops from last beat until the result handshake; results hold while out_ready=0.
module spmv_row_accumulator #(
    parameter int DATA_W = 24,
    parameter int ACC_W  = 32,
    parameter int LANES  = 4,
    parameter int ROW_W  = 11,
    parameter int CNT_W  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    spmv_row_accumulator_if.slave bus
);
    localparam int STAGES = $clog2(LANES);
    localparam int PTR_W  = (LANES > 1) ? STAGES : 1;
    localparam int STG_W  = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic [1:0] {ACCUM, REDUCE, HOLD} state_t;

    state_t             state;
    logic [ACC_W-1:0]   lane     [LANES];
    logic [ACC_W-1:0]   lane_nxt [LANES];
    logic [PTR_W-1:0]   lane_ptr;
    logic [STG_W-1:0]   stage;
    logic [CNT_W-1:0]   nnz;
    logic [ROW_W-1:0]   row_q;
    logic               sat_flag;
    logic               sat_hit;
    logic               rdy_q;
    logic               vld_q;
    logic               take;
    logic [ACC_W-1:0]   in_ext;
    logic [ACC_W:0]     sum_r;

    // Returns {overflow, sum}; overflow is only ever reported when saturating.
    function automatic logic [ACC_W:0] add_acc(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        logic [ACC_W-1:0] s;
        logic             ovf;
        s = a + b;
`ifdef SATURATE_EN
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
        if (ovf) begin
            s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
`else
        ovf = 1'b0;
`endif
        return {ovf, s};
    endfunction

    assign in_ext = ACC_W'($signed(bus.in_data));
    assign take   = bus.in_valid && rdy_q;

    always_comb begin
        sat_hit = 1'b0;
        sum_r   = '0;
        for (int i = 0; i < LANES; i++) lane_nxt[i] = lane[i];
        case (state)
            ACCUM: begin
                if (take) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (lane_ptr == PTR_W'(i)) begin
                            sum_r       = add_acc(lane[i], in_ext);
                            lane_nxt[i] = sum_r[ACC_W-1:0];
                            sat_hit     = sum_r[ACC_W];
                        end
                    end
                end
            end
            REDUCE: begin
                // Only pairs live at this stage are summed so dead lanes cannot raise the flag.
                for (int i = 0; i < LANES / 2; i++) begin
                    if (i < (LANES >> (int'(stage) + 1))) begin
                        sum_r       = add_acc(lane[2*i], lane[2*i+1]);
                        lane_nxt[i] = sum_r[ACC_W-1:0];
                        sat_hit     = sat_hit | sum_r[ACC_W];
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    for (int i = 0; i < LANES; i++) lane_nxt[i] = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ACCUM;
            for (int i = 0; i < LANES; i++) lane[i] <= '0;
            lane_ptr <= '0;
            stage    <= '0;
            nnz      <= '0;
            row_q    <= '0;
            sat_flag <= 1'b0;
            rdy_q    <= 1'b1;
            vld_q    <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) lane[i] <= lane_nxt[i];
            case (state)
                ACCUM: begin
                    if (take) begin
                        lane_ptr <= (LANES == 1) ? '0 : lane_ptr + 1'b1;
                        nnz      <= nnz + 1'b1;
                        sat_flag <= sat_flag | sat_hit;
                        if (bus.in_last) begin
                            row_q <= bus.in_row;
                            rdy_q <= 1'b0;
                            stage <= '0;
                            if (LANES == 1) begin
                                state <= HOLD;
                                vld_q <= 1'b1;
                            end else begin
                                state <= REDUCE;
                            end
                        end
                    end
                end
                REDUCE: begin
                    sat_flag <= sat_flag | sat_hit;
                    stage    <= stage + 1'b1;
                    if (stage == STG_W'(STAGES - 1)) begin
                        state <= HOLD;
                        vld_q <= 1'b1;
                        stage <= '0;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        lane_ptr <= '0;
                        nnz      <= '0;
                        sat_flag <= 1'b0;
                        vld_q    <= 1'b0;
                        rdy_q    <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    // lane[0], nnz and the row latch are frozen in HOLD, so they drive the result directly.
    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_q;
    assign bus.out_data  = lane[0];
    assign bus.out_row   = row_q;
    assign bus.out_nnz   = nnz;
    assign bus.out_sat   = sat_flag;
endmodule

// File: doc/spmv_row_accumulator.md
Name: spmv_row_accumulator

Overview:
- Parametrised successor to the fixed 4-way controller/adder-tree accumulation path of the SpMV datapath.
- Consumes a stream of signed products, one per beat, each tagged with a row number and an end-of-row marker.
- Accumulates the products round-robin into LANES interleaved partial sums, then reduces them through a registered pairwise tree.
- Presents one row result per row on a valid/ready output; sits between the multiplier and the y-vector writeback.

Parameters:
DATA_W, 24, width of signed input product
ACC_W, 32, width of lane accumulators and result (ACC_W >= DATA_W)
LANES, 4, number of interleaved partial accumulators; power of 2, 1..16
ROW_W, 11, width of row index
CNT_W, 8, width of per-row nonzero counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
in_valid  in  1  product beat valid
in_ready  out  1  block can accept a beat
in_data  in  DATA_W  signed product
in_row  in  ROW_W  row index of the beat; sampled on the in_last beat
in_last  in  1  beat is the final product of its row
out_valid  out  1  row result valid
out_ready  in  1  downstream accepts the result
out_data  out  ACC_W  signed row sum
out_row  out  ROW_W  row index of the result
out_nnz  out  CNT_W  number of beats accumulated for the row
out_sat  out  1  saturation occurred in this row (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - all lanes, lane_ptr, nnz, reduction stage counter and flags cleared; state ACCUM.
  - out_valid=0, out_data=0, out_row=0, out_nnz=0, out_sat=0, in_ready=1.
- A beat is accepted when in_valid and in_ready are both high in the same cycle.
- States:
  - ACCUM: in_ready=1.
    - Each accepted beat: lane[lane_ptr] <= lane[lane_ptr] + sign_extend(in_data); lane_ptr <= (lane_ptr+1) mod LANES; nnz <= nnz+1, wrapping at 2^CNT_W.
    - An accepted beat with in_last=1 is accumulated normally, in_row is latched, and the state moves to REDUCE, or straight to HOLD when LANES=1.
  - REDUCE: in_ready=0; lasts log2(LANES) cycles.
    - In stage k (0-based): lane[i] <= lane[2i] + lane[2i+1] for i < LANES>>(k+1).
    - After the final stage, lane[0] holds the row sum; move to HOLD.
  - HOLD: in_ready=0; out_valid=1; out_data=lane[0], out_row=latched row, out_nnz=nnz, out_sat=row flag.
    - All outputs stay stable while out_ready=0.
    - On out_ready=1: clear lanes, lane_ptr, nnz and sat flag; out_valid falls the next cycle; return to ACCUM.
- Latency: last beat accepted in cycle t -> out_valid first high in cycle t+1+log2(LANES).
- Throughput: one beat per cycle within a row. A bubble of log2(LANES)+1 cycles minimum occurs between rows.
- in_valid high while in_ready=0: no beat is taken; the upstream must hold the beat.
- Single-beat row (first beat has in_last=1): legal; result equals the sign-extended product with out_nnz=1.
- A row with zero beats cannot be expressed; an empty row is signalled to the writeback by a separate path.
- Arithmetic: two's complement, ACC_W bits; wrap-around on overflow unless SATURATE_EN is defined.
- Reset asserted mid-row or mid-REDUCE/HOLD: partial results are discarded and no output is produced for that row.

Optional Feature:
- Macro SATURATE_EN.
- Defined:
  - every lane addition and tree addition saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1];
  - any saturation within a row sets a sticky flag, reported on out_sat in HOLD and cleared on handshake.
- Not defined: additions wrap modulo 2^ACC_W and out_sat is tied to 0.

Test Plan:
- Reset, LANES=4, row 5: beats 1,2,3,4,5 (last on 5) -> out_valid at last+3 with out_data=15, out_row=5, out_nnz=5.
- Single beat -7, in_last=1, row 0x7FF -> out_data=-7 (0xFFFFFFF9), out_nnz=1, out_row=0x7FF.
- Hold out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0, outputs stable, no beat consumed. Then out_ready=1 -> next row's first beat accepted the cycle after out_valid falls.
- ACC_W=DATA_W=24, four beats of 0x7FFFFF:
  - SATURATE_EN defined -> out_data=0x7FFFFF, out_sat=1.
  - SATURATE_EN not defined -> out_data=0xFFFFFC (wrapped), out_sat=0.
- Reset pulse in the second REDUCE cycle -> out_valid never asserts. A following row 3 with beats 10,-4 gives out_data=6, out_nnz=2.
- LANES=1, beats 2,3 -> out_valid the cycle after the last beat with out_data=5. LANES=16, 20 beats of 1 -> out_data=20 after 5 cycles.
